// File: rtl/kmap2_sweep.sv
// kmap2_sweep: drives a 2-input combinational function through all four input combinations
// and captures its truth table. Define KMAP_SWEEP_CLASSIFY_EN to add the registered NAND classification flag.
module kmap2_sweep (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_probe_f,
  output logic       o_probe_a,
  output logic       o_probe_b,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_table,
  output logic       o_match_nand
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_stateNext;
  logic [1:0] r_idx;
  logic [3:0] r_shadow;
  logic [3:0] r_table;
  logic [3:0] w_shadowNext;
  logic       w_lastSample;

  // Shadow image including the sample being taken this cycle, so the final
  // write and the table publish can happen on the same edge.
  always_comb begin
    w_shadowNext         = r_shadow;
    w_shadowNext[r_idx]  = i_probe_f;
  end

  assign w_lastSample = (r_state == S_SAMPLE) && (r_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_idx    <= 2'd0;
      r_shadow <= 4'b0000;
      r_table  <= 4'b0000;
    end else begin
      r_state <= w_stateNext;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_idx    <= 2'd0;
            r_shadow <= 4'b0000;
          end
        end
        S_SAMPLE: begin
          r_shadow <= w_shadowNext;
          if (r_idx == 2'd3) begin
            r_table <= w_shadowNext;
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_stateNext = r_state;
    o_probe_a   = 1'b0;
    o_probe_b   = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_stateNext = S_DRIVE;
        end
      end
      S_DRIVE: begin
        o_probe_a   = r_idx[1];
        o_probe_b   = r_idx[0];
        w_stateNext = S_SAMPLE;
      end
      S_SAMPLE: begin
        o_probe_a   = r_idx[1];
        o_probe_b   = r_idx[0];
        w_stateNext = (r_idx == 2'd3) ? S_DONE : S_DRIVE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  assign o_table = r_table;

`ifdef KMAP_SWEEP_CLASSIFY_EN
  logic r_matchNand;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_matchNand <= 1'b0;
    end else if (w_lastSample) begin
      r_matchNand <= (w_shadowNext == 4'b0111);
    end
  end

  assign o_match_nand = r_matchNand;
`else
  assign o_match_nand = 1'b0;
`endif

endmodule

// File: doc/kmap2_sweep.md
KMAP2_SWEEP -- requirements
Module: kmap2_sweep

Interface
REQ-001 SHALL have one clock and a synchronous active-low reset; clock and reset ports listed first.
REQ-002 SHALL have port clk, input, 1 bit: sole clock, all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low (0 = reset), sampled on the rising edge of clk.
REQ-004 SHALL have port start, input, 1 bit: request one truth-table sweep; sampled only in IDLE.
REQ-005 SHALL have port probe_f, input, 1 bit: response of the observed 2-input combinational function.
REQ-006 SHALL have port probe_a, output, 1 bit: drives input a of the observed function.
REQ-007 SHALL have port probe_b, output, 1 bit: drives input b of the observed function.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking a completed sweep.
REQ-010 SHALL have port table, output, 4 bits: captured truth table, with table[{a,b}] = f(a,b).
REQ-011 SHALL have port match_nand, output, 1 bit: classification flag, see REQ-025.

Function
REQ-012 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE with a 2-bit combination index idx.
REQ-013 IDLE: if start=1 on an edge, SHALL clear idx to 0 and the shadow table, then go to DRIVE; otherwise SHALL stay in IDLE.
REQ-014 DRIVE and SAMPLE SHALL drive {probe_a,probe_b} = idx; in IDLE and DONE both SHALL be 0.
REQ-015 DRIVE SHALL last exactly one cycle and then go to SAMPLE; this is the settle cycle, and probe_f is ignored.
REQ-016 At the edge ending SAMPLE, SHALL write probe_f into shadow[idx].
REQ-017 At that same edge: if idx==3, SHALL go to DONE; otherwise SHALL increment idx and go to DRIVE.
REQ-018 DONE SHALL last one cycle with done=1 and table=shadow, then go to IDLE.
REQ-019 Latency: start accepted at edge 0 → DRIVE in cycles 1,3,5,7, SAMPLE in cycles 2,4,6,8, done=1 in cycle 9; a sweep takes 10 cycles including IDLE.
REQ-020 table SHALL update only on entry to DONE and SHALL hold between sweeps; a partial sweep SHALL never be visible on table.
REQ-021 start SHALL be ignored while busy=1; no queuing.
REQ-022 start held high continuously SHALL give back-to-back sweeps, with done pulsing every 10 cycles.
REQ-023 probe_f SHALL be treated as opaque; no assumption about what function it computes.

Reset
REQ-024 With reset=0 at an edge, in any state including mid-sweep, the block SHALL enter IDLE with idx=0, shadow=0, table=4'b0000, probe_a=0, probe_b=0, busy=0, done=0 and match_nand=0; a partial sweep SHALL be discarded.

Configuration
REQ-025 Macro KMAP_SWEEP_CLASSIFY_EN:
- Defined: match_nand SHALL be registered, updated with table on entry to DONE, equal to (shadow==4'b0111), and held until the next DONE or reset.
- Undefined: match_nand SHALL be constant 0, with no comparator logic.

Verification
REQ-026 Observed function NAND, start pulsed at edge 0 → done=1 in cycle 9, table=4'b0111, match_nand=1 (macro defined) or 0 (undefined).
REQ-027 Observed function AND → table=4'b1000, match_nand=0; then observed function constant 1 → table=4'b1111, match_nand=0.
REQ-028 Per-cycle probe check during a sweep → {probe_a,probe_b} = 00,00,01,01,10,10,11,11 over cycles 1-8, and 00 in cycle 9.
REQ-029 start held high for 30 cycles with observed function XOR → done high in cycles 9, 19, 29, table=4'b0110 each time, busy low only in cycles 0, 10, 20.
REQ-030 reset=0 at the edge ending cycle 6 (SAMPLE of idx=2) after a prior NAND sweep → in cycle 7 IDLE, table=4'b0000, probes 0, no done pulse.
REQ-031 start pulsed in cycle 4 of an active sweep → ignored; done occurs only in cycle 9, and no second sweep follows.
